// File: rtl/serial_subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int SERIAL_SUB_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: diff = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin, LSB first, one cell reused
// over WIDTH cycles behind a start/done handshake.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > SERIAL_SUB_MAX_WIDTH) begin : g_width_check
            $fatal(1, "serial_subtractor: WIDTH must be in 2..%0d", SERIAL_SUB_MAX_WIDTH);
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic               r_amsb;
    logic               r_bmsb;
    logic               r_bout;
    logic               r_ovf;
    logic               w_d;
    logic               w_bn;
    logic               w_accept;
    logic               w_last;

    full_subtractor u_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_br),
        .diff (w_d),
        .bout (w_bn)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Result bits enter from the MSB side so bit 0 lands in place after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_sa   <= a;
            r_sb   <= b;
            r_br   <= bin;
            r_cnt  <= '0;
            r_amsb <= a[WIDTH-1];
            r_bmsb <= b[WIDTH-1];
        end else if (r_state == RUN) begin
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_sa   <= r_sa >> 1;
            r_sb   <= r_sb >> 1;
            r_br   <= w_bn;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_bout <= w_bn;
                r_ovf  <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            end
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign diff  = r_diff;
    assign bout  = r_bout;
    assign ovf   = r_ovf;

endmodule
